// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit feeding the register file write port
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     flush,
  input  logic [2:0]               funct3,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  input  logic [ADDRESS_WIDTH-1:0] rd_in,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [ADDRESS_WIDTH-1:0] rd_out
);

  localparam int W = DATA_WIDTH;

  state_e                   state_q;
  logic [2:0]               funct3_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [W-1:0]             a_q;
  logic [W-1:0]             b_q;
  logic [2*W-1:0]           acc_q;
  logic [2*W-1:0]           acc_d;
  logic [5:0]               cnt_q;
  logic                     neg_q;
  logic                     busy_q;
  logic                     done_q;
  logic [W-1:0]             result_q;

  logic         a_signed, b_signed, a_neg, b_neg, neg_d;
  logic         is_div, div_zero, div_ovf;
  logic [W-1:0] a_mag, b_mag, fast_res;

  logic [W:0]   mul_sum;
  logic [W:0]   rem_shift;
  logic [W-1:0] rem_diff;
  logic         rem_ge;

  // Sign fix and result selection; acc holds {hi, lo} = product, or {remainder, quotient}
  function automatic logic [W-1:0] fix_result(input logic [2:0] f3, input logic neg,
                                              input logic [2*W-1:0] acc);
    logic [2*W-1:0] prod;
    logic [W-1:0]   part;
    prod = neg ? -acc : acc;
    part = f3[1] ? acc[2*W-1:W] : acc[W-1:0];
    if (!f3[2]) begin
      return (f3 == F3_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    end
    return neg ? -part : part;
  endfunction

  // Acceptance-time decode: operand magnitudes, result sign and the divide fast paths
  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed & op_a[W-1];
    b_neg    = b_signed & op_b[W-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    // Remainders follow the dividend; products and quotients follow the sign XOR
    neg_d    = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (op_b == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (op_a == INT_MIN) && (op_b == DIV0_QUOT);
    fast_res = '0;
    if (div_zero) begin
      fast_res = funct3[1] ? op_a : DIV0_QUOT;
    end else if (div_ovf) begin
      fast_res = funct3[1] ? '0 : INT_MIN;
    end
  end

  // One iteration: shift-add multiply step or restoring divide step
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    rem_shift = acc_q[2*W-1:W-1];
    rem_ge    = (rem_shift >= {1'b0, b_q});
    rem_diff  = rem_shift[W-1:0] - b_q;
    if (state_q == S_MUL) begin
      acc_d = {mul_sum, acc_q[W-1:1]};
    end else if (rem_ge) begin
      acc_d = {rem_diff, acc_q[W-2:0], 1'b1};
    end else begin
      acc_d = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            funct3_q <= funct3;
            rd_q     <= rd_in;
            a_q      <= a_mag;
            b_q      <= b_mag;
            neg_q    <= neg_d;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (div_zero || div_ovf) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              acc_q   <= is_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
              state_q <= is_div ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'(ITER_COUNT - 1)) begin
              result_q <= fix_result(funct3_q, neg_q, acc_d);
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q & ~flush;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) n_done++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference results from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = '0;
    if (f[2] && b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    case (f)
      3'b000: p = sa * sb;
      3'b001: p = sa * sb;
      3'b010: p = sa * ub;
      3'b011: p = ua * ub;
      3'b100: p = sa / sb;
      3'b101: p = ua / ub;
      3'b110: p = sa % sb;
      default: p = ua % ub;
    endcase
    if (f == 3'b001 || f == 3'b010 || f == 3'b011) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op right after a negedge, wait for done, check result, latency and busy span
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int dup_at);
    logic [31:0] exp_res;
    int exp_lat, lat, busy_cycles, d0;
    exp_res = ref_result(f, a, b);
    exp_lat = ref_latency(f, a, b);
    #1;
    d0 = n_done;
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    lat = 0; busy_cycles = 0;
    while (lat < 60) begin
      @(negedge clk); #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
      end
      if (dup_at != 0 && lat == dup_at) begin
        start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = ~rd;
      end else if (dup_at != 0 && lat == dup_at + 1) begin
        start = 1'b0;
      end
      if (busy) busy_cycles++;
      if (done) break;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " rd_out"}, 64'(rd_out), 64'(rd));
    check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(exp_lat));
    @(negedge clk); #1;
    check({tag, " done_after"}, 64'(done), 64'd0);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " done_pulses"}, 64'(n_done - d0), 64'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset rd_out", 64'(rd_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_7x6", F3_MUL, 32'd7, 32'd6, 5'd5, 0);
    check("mul_7x6 const", 64'(result), 64'd42);
    @(negedge clk); run_op("mulh_ff", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
    @(negedge clk); run_op("mulhu_ff", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    check("mulhu const", 64'(result), 64'hFFFF_FFFE);
    @(negedge clk); run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3, 0);
    @(negedge clk); run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    check("div const", 64'(result), 64'hFFFF_FFFD);
    @(negedge clk); run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    @(negedge clk); run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 5'd7, 0);
    @(negedge clk); run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 5'd8, 0);
    @(negedge clk); run_op("divu_by0", F3_DIVU, 32'd123, 32'd0, 5'd9, 0);
    @(negedge clk); run_op("rem_by0", F3_REM, 32'd123, 32'd0, 5'd10, 0);
    check("rem_by0 const", 64'(result), 64'd123);
    @(negedge clk); run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    @(negedge clk); run_op("dup_start", F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 10);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      run_op($sformatf("rand%0d", i), 3'($urandom), rand_word(), rand_word(), 5'($urandom), 0);
    end

    // flush and start together in IDLE: request dropped
    @(negedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = F3_MUL; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", 64'(busy), 64'd0);

    // flush in cycle c15 of a DIV
    @(negedge clk); #1;
    d0 = n_done;
    start = 1'b1; funct3 = F3_DIV; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd12;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    run_op("after_flush", F3_REM, 32'hFFFF_FC18, 32'd7, 5'd13, 0);
    check("flush total pulses", 64'(n_done - d0), 64'd1);

    // reset in cycle c20 of a MUL
    @(negedge clk); #1;
    d0 = n_done;
    start = 1'b1; funct3 = F3_MUL; op_a = 32'd99; op_b = 32'd77; rd_in = 5'd14;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (19) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst result", 64'(result), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    run_op("after_rst", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd15, 0);
    check("rst total pulses", 64'(n_done - d0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file. It takes the two register-file read operands and returns a 32-bit result, destination index and one-cycle write strobe. These drive the register file write port (result to WD3, rd_out to AD3, done to WE3). It is multi-cycle: one operation at a time, with a start/busy/done handshake to the pipeline control.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported.
ADDRESS_WIDTH, 5, register index width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only in IDLE
flush  input  1  synchronous abort of the in-flight operation
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  DATA_WIDTH  rs1 value (register file RD1)
op_b  input  DATA_WIDTH  rs2 value (register file RD2)
rd_in  input  ADDRESS_WIDTH  destination register index
busy  output  1  high from the cycle after acceptance until DONE is left
done  output  1  one-cycle pulse; result and rd_out are valid while high
result  output  DATA_WIDTH  final result
rd_out  output  ADDRESS_WIDTH  captured rd_in

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, result=0, rd_out=0; all internal registers 0.
- States are IDLE, MUL, DIV, DONE.
- IDLE:
  - On start=1, capture funct3, rd_in, |op_a| and |op_b| (magnitudes for signed ops), and the result sign.
  - Clear the iteration counter; go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- Fast paths (DIV ops only): go IDLE -> DONE directly, so done is high in the cycle after start.
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- MUL: shift-add, one multiplier bit per cycle, exactly 32 cycles, into a 64-bit accumulator. Then go to DONE.
- DIV: restoring division, one quotient bit per cycle, exactly 32 cycles. Then go to DONE.
- Normal latency: start high in cycle c0; iterations in c1..c32; done high in c33. Busy is high c1..c33.
- DONE: apply sign fix, drive result and done=1 for exactly one cycle, then return to IDLE. No back-pressure.
- Result selection:
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
  - MULH: both operands signed. MULHSU: op_a signed, op_b unsigned. MULHU and DIVU/REMU: unsigned.
  - Signed product is negated when the operand signs differ.
  - Quotient sign is sign(a) XOR sign(b); remainder takes the sign of the dividend.
- rd_out: driven with the captured index from acceptance onward and held until the next acceptance. An rd of 0 is passed through unchanged; the register file ignores the write.
- Boundary conditions:
  - start while busy or in DONE: ignored; no capture, no queueing.
  - flush=1 in MUL/DIV/DONE: next state IDLE; done is forced 0 in that cycle and the next; result holds its old value.
  - flush and start together in IDLE: flush wins and the request is dropped.
  - Operands are sampled only at acceptance; changes on op_a/op_b afterwards have no effect.
  - Reset asserted mid-operation: immediate IDLE, no done pulse.

Decomposition:
- Shared package muldiv_pkg holds:
  - the funct3 enum (MUL..REMU);
  - the state enum (IDLE, MUL, DIV, DONE);
  - the constants ITER_COUNT=32, DIV0_QUOT=32'hFFFF_FFFF, INT_MIN=32'h8000_0000.
- Single module; no sub-module needed. The sign-fix/negation logic stays an internal function.

Test Plan:
- Reset, then MUL with op_a=7, op_b=6, rd_in=5 -> done pulses exactly 33 cycles after start; result=42, rd_out=5; busy high for 33 cycles.
- MULH with 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; MULHU with the same operands -> 0xFFFFFFFE; MULHSU(0xFFFFFFFF, 2) -> 0xFFFFFFFF.
- DIV(-7, 2) -> 0xFFFFFFFD (-3); REM(-7, 2) -> 0xFFFFFFFF (-1); DIVU(100, 7) -> 14; REMU(100, 7) -> 2.
- DIVU(123, 0) -> 0xFFFFFFFF and REM(123, 0) -> 123, each with done in the cycle after start; DIV(0x80000000, 0xFFFFFFFF) -> 0x80000000 with 1-cycle latency.
- Second start issued at cycle c10 of a running op -> ignored; only one done pulse, at c33, with the first op's result.
- flush at c15 of a DIV, and separately rst at c20 of a MUL -> no done pulse; state IDLE; a new start is accepted on the next cycle and completes correctly.
